mem_port_arbiter: RTL and testbench

- Shares the core's single-ported unified memory between three requesters: instruction fetch (32-bit read), data load (64-bit read) and store (64-bit write).
- Sits between the core control FSM and the byte memory. Replaces the current three independent combinational memory interfaces with one sequenced port.
- Uses per-requester req/gnt handshakes and a fixed-latency read-return path.
- Allows at most one transaction to be in flight at a time.

---
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the three requester handshakes (fetch, load, store) and the single
// memory port used by mem_port_arbiter.
//   slave  : arbiter view (receives requests and mem_rdata, drives grants,
//            read returns, the memory strobe/address/data and busy)
//   master : environment view (core requesters plus the memory itself)
// Parameter ADDR_W sets the byte-address width of every address signal.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [31:0]       f_rdata;

  logic              l_req;
  logic [ADDR_W-1:0] l_addr;
  logic              l_gnt;
  logic              l_rvalid;
  logic [63:0]       l_rdata;

  logic              s_req;
  logic [ADDR_W-1:0] s_addr;
  logic [63:0]       s_data;
  logic              s_gnt;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic [63:0]       mem_rdata;

  logic              busy;

  modport slave (
    input  f_req, f_addr, l_req, l_addr, s_req, s_addr, s_data, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, s_gnt,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output f_req, f_addr, l_req, l_addr, s_req, s_addr, s_data, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, s_gnt,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Sequences fetch (32-bit read), load (64-bit read) and store (64-bit write)
// requests onto one single-ported memory with at most one transaction in
// flight. Grants are combinational and only issue while the port is free
// (IDLE, or the RD_WAIT cycle in which the read latency expires). Reads
// return exactly RD_LAT cycles after their grant; stores commit on the
// grant edge, so stores can issue every cycle.
//
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-high
//   bus   - mem_port_arbiter_if.slave: f_/l_/s_ req/gnt handshakes,
//           f_/l_ rvalid/rdata returns, mem_en/we/addr/wdata/rdata, busy
// Parameters:
//   ADDR_W - byte-address width (must match the interface)
//   RD_LAT - memory read latency in cycles, 1..15
// Build option:
//   MEM_ARB_ROUND_ROBIN_EN - when defined, rotating priority starting after
//   the last granted requester (fetch -> load -> store -> fetch); when
//   undefined, fixed priority store > load > fetch.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic {IDLE, RD_WAIT} state_e;
  typedef enum logic [1:0] {
    REQ_F    = 2'd0,
    REQ_L    = 2'd1,
    REQ_S    = 2'd2,
    REQ_NONE = 2'd3
  } req_e;

  localparam logic [3:0] LAT_LOAD = 4'(RD_LAT);

  state_e            state_q;
  logic [3:0]        cnt_q;
  req_e              owner_q;
  logic              busy_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  req_e              ptr_q;
`endif

  logic              expire;
  logic              port_free;
  req_e              win;
  logic [ADDR_W-1:0] addr_sel;
  logic              f_rv;
  logic              l_rv;

  // The read in flight returns its data in the last RD_WAIT cycle; that same
  // cycle already counts as a free port so reads can run back to back.
  assign expire    = (state_q == RD_WAIT) && (cnt_q == 4'd1);
  assign port_free = (state_q == IDLE) || expire;

  always_comb begin
    win = REQ_NONE;
    if (port_free && !reset) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      // Search starts at the requester after the last granted one.
      case (ptr_q)
        REQ_F: begin
          if (bus.l_req)      win = REQ_L;
          else if (bus.s_req) win = REQ_S;
          else if (bus.f_req) win = REQ_F;
        end
        REQ_L: begin
          if (bus.s_req)      win = REQ_S;
          else if (bus.f_req) win = REQ_F;
          else if (bus.l_req) win = REQ_L;
        end
        default: begin
          if (bus.f_req)      win = REQ_F;
          else if (bus.l_req) win = REQ_L;
          else if (bus.s_req) win = REQ_S;
        end
      endcase
`else
      if (bus.s_req)      win = REQ_S;
      else if (bus.l_req) win = REQ_L;
      else if (bus.f_req) win = REQ_F;
`endif
    end
  end

  always_comb begin
    addr_sel = '0;
    case (win)
      REQ_F:   addr_sel = bus.f_addr;
      REQ_L:   addr_sel = bus.l_addr;
      REQ_S:   addr_sel = bus.s_addr;
      default: addr_sel = '0;
    endcase
  end

  assign bus.f_gnt     = (win == REQ_F);
  assign bus.l_gnt     = (win == REQ_L);
  assign bus.s_gnt     = (win == REQ_S);
  assign bus.mem_en    = (win != REQ_NONE);
  assign bus.mem_we    = (win == REQ_S);
  assign bus.mem_addr  = addr_sel;
  assign bus.mem_wdata = (win == REQ_S) ? bus.s_data : 64'h0;

  // A read cut off by reset never reports its data.
  assign f_rv = expire && (owner_q == REQ_F) && !reset;
  assign l_rv = expire && (owner_q == REQ_L) && !reset;

  assign bus.f_rvalid = f_rv;
  assign bus.l_rvalid = l_rv;
  assign bus.f_rdata  = f_rv ? bus.mem_rdata[31:0] : 32'h0;
  assign bus.l_rdata  = l_rv ? bus.mem_rdata : 64'h0;
  assign bus.busy     = busy_q && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      owner_q <= REQ_F;
      busy_q  <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_q   <= REQ_F;
`endif
    end else begin
      if (win == REQ_F || win == REQ_L) begin
        state_q <= RD_WAIT;
        cnt_q   <= LAT_LOAD;
        owner_q <= win;
        busy_q  <= 1'b1;
      end else if (expire) begin
        state_q <= IDLE;
        cnt_q   <= 4'd0;
        busy_q  <= 1'b0;
      end else if (state_q == RD_WAIT) begin
        cnt_q   <= cnt_q - 4'd1;
      end
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (win != REQ_NONE) ptr_q <= win;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int RD_LAT = 2;

  typedef struct {
    int          cyc;
    int          who;
    logic [31:0] addr;
    logic [63:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32)) bus ();
  mem_port_arbiter_if #(.ADDR_W(32)) bus1 ();

  mem_port_arbiter #(.ADDR_W(32), .RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  mem_port_arbiter #(.ADDR_W(32), .RD_LAT(1)) dut1 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus1)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  // ---------------- memory environment ----------------
  logic [63:0] envmem [logic [31:0]];
  logic [63:0] refmem [logic [31:0]];
  logic [63:0] pipe [RD_LAT];
  logic [63:0] pipe1;

  function automatic logic [63:0] dflt(input logic [31:0] a);
    return {a ^ 32'hC0DE_0000, ~a};
  endfunction

  function automatic logic [63:0] env_rd(input logic [31:0] a);
    return envmem.exists(a) ? envmem[a] : dflt(a);
  endfunction

  function automatic logic [63:0] ref_rd(input logic [31:0] a);
    return refmem.exists(a) ? refmem[a] : dflt(a);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) envmem[bus.mem_addr] = bus.mem_wdata;
    pipe[0] <= (bus.mem_en && !bus.mem_we) ? env_rd(bus.mem_addr) : 64'h0;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    pipe1 <= (bus1.mem_en && !bus1.mem_we) ? dflt(bus1.mem_addr) : 64'h0;
  end

  assign bus.mem_rdata  = pipe[RD_LAT-1];
  assign bus1.mem_rdata = pipe1;

  // ---------------- checking helper ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  exp_t gq[$], rq[$], gq1[$], rq1[$];
  bit          req [3];
  logic [31:0] ra  [3];
  logic [63:0] sd;
  bit          want [3];
  logic [31:0] wa  [3];
  logic [63:0] wd;
  int  last_w   = -1;
  int  last_rd  = -1000;
  int  free_cyc = 0;
  int  rr_last  = 0;
  bit  busy_exp = 1'b0;

  // Requester index: 0 fetch, 1 load, 2 store.
  function automatic int pick();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= 3; k++)
      if (req[(rr_last + k) % 3]) return (rr_last + k) % 3;
`else
    for (int k = 2; k >= 0; k--)
      if (req[k]) return k;
`endif
    return -1;
  endfunction

  task automatic model_step();
    int w;
    w = -1;
    if (rst) begin
      busy_exp = 1'b0;
      rq.delete();
      last_rd  = -1000;
      free_cyc = cyc + 1;
      rr_last  = 0;
    end else begin
      busy_exp = (cyc <= last_rd + RD_LAT);
      if (cyc >= free_cyc) w = pick();
      if (w == 2) begin
        gq.push_back('{cyc, 2, ra[2], sd});
        refmem[ra[2]] = sd;
      end else if (w >= 0) begin
        gq.push_back('{cyc, w, ra[w], 64'h0});
        rq.push_back('{cyc + RD_LAT, w, ra[w], ref_rd(ra[w])});
        last_rd  = cyc;
        free_cyc = cyc + RD_LAT;
      end
      if (w >= 0) rr_last = w;
    end
    last_w = w;
  endtask

  task automatic drive();
    bus.f_req  = req[0];
    bus.f_addr = ra[0];
    bus.l_req  = req[1];
    bus.l_addr = ra[1];
    bus.s_req  = req[2];
    bus.s_addr = ra[2];
    bus.s_data = sd;
  endtask

  task automatic want_req(input int i, input logic [31:0] a, input logic [63:0] d);
    want[i] = 1'b1;
    wa[i]   = a;
    if (i == 2) wd = d;
  endtask

  task automatic step(input bit rnd, input bit r);
    @(posedge clk);
    #1;
    cyc++;
    rst = r;
    if (last_w >= 0) req[last_w] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (want[i]) begin
        req[i]  = 1'b1;
        ra[i]   = wa[i];
        if (i == 2) sd = wd;
        want[i] = 1'b0;
      end
    end
    if (rnd) begin
      rst = ($urandom_range(0, 249) == 0);
      for (int i = 0; i < 3; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req[i] = 1'b1;
            ra[i]  = 32'h100 + 32'(8 * $urandom_range(0, 7));
            if (i == 2) sd = {$urandom, $urandom};
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    drive();
    model_step();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0);
  endtask

  // ---------------- monitor: main port ----------------
  exp_t       m_eg, m_er;
  logic [2:0] m_g;
  logic [1:0] m_rv;
  bit         m_gdue, m_rdue;

  always @(negedge clk) begin
    if (mon_en) begin
      m_g    = {bus.s_gnt, bus.l_gnt, bus.f_gnt};
      m_gdue = (gq.size() > 0) && (gq[0].cyc == cyc);
      if (m_g != 3'b0 || m_gdue) begin
        if (m_gdue) begin
          m_eg = gq.pop_front();
          chk("gnt", 64'(m_g), 64'(3'b001 << m_eg.who));
          chk("mem_en", 64'(bus.mem_en), 64'd1);
          chk("mem_we", 64'(bus.mem_we), 64'(m_eg.who == 2));
          chk("mem_addr", 64'(bus.mem_addr), 64'(m_eg.addr));
          chk("mem_wdata", bus.mem_wdata, (m_eg.who == 2) ? m_eg.data : 64'h0);
        end else begin
          chk("unexpected_gnt", 64'(m_g), 64'd0);
        end
      end else begin
        chk("idle_mem_ctl", 64'({bus.mem_en, bus.mem_we}), 64'd0);
        chk("idle_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("idle_mem_wdata", bus.mem_wdata, 64'h0);
      end

      m_rv   = {bus.l_rvalid, bus.f_rvalid};
      m_rdue = (rq.size() > 0) && (rq[0].cyc == cyc);
      if (m_rv != 2'b0 || m_rdue) begin
        if (m_rdue) begin
          m_er = rq.pop_front();
          chk("rvalid", 64'(m_rv), (m_er.who == 1) ? 64'd2 : 64'd1);
          chk("f_rdata", 64'(bus.f_rdata), (m_er.who == 0) ? 64'(m_er.data[31:0]) : 64'h0);
          chk("l_rdata", bus.l_rdata, (m_er.who == 1) ? m_er.data : 64'h0);
        end else begin
          chk("unexpected_rvalid", 64'(m_rv), 64'd0);
        end
      end else begin
        chk("idle_f_rdata", 64'(bus.f_rdata), 64'h0);
        chk("idle_l_rdata", bus.l_rdata, 64'h0);
      end
      chk("busy", 64'(bus.busy), 64'(busy_exp));
    end
  end

  // ---------------- monitor: RD_LAT=1 port ----------------
  exp_t m1_e;
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus1.f_gnt || (gq1.size() > 0 && gq1[0].cyc == cyc)) begin
        if (gq1.size() > 0 && gq1[0].cyc == cyc) begin
          m1_e = gq1.pop_front();
          chk("lat1_f_gnt", 64'(bus1.f_gnt), 64'd1);
          chk("lat1_mem_addr", 64'(bus1.mem_addr), 64'(m1_e.addr));
        end else begin
          chk("lat1_unexpected_gnt", 64'(bus1.f_gnt), 64'd0);
        end
      end
      if (bus1.f_rvalid || (rq1.size() > 0 && rq1[0].cyc == cyc)) begin
        if (rq1.size() > 0 && rq1[0].cyc == cyc) begin
          m1_e = rq1.pop_front();
          chk("lat1_f_rvalid", 64'(bus1.f_rvalid), 64'd1);
          chk("lat1_f_rdata", 64'(bus1.f_rdata), 64'(m1_e.data[31:0]));
        end else begin
          chk("lat1_unexpected_rvalid", 64'(bus1.f_rvalid), 64'd0);
        end
      end else begin
        chk("lat1_idle_f_rdata", 64'(bus1.f_rdata), 64'h0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 3; i++) begin
      req[i]  = 1'b0;
      ra[i]   = 32'h0;
      want[i] = 1'b0;
      wa[i]   = 32'h0;
    end
    sd = 64'h0;
    wd = 64'h0;
    drive();
    bus1.f_req  = 1'b0;
    bus1.f_addr = 32'h0;
    bus1.l_req  = 1'b0;
    bus1.l_addr = 32'h0;
    bus1.s_req  = 1'b0;
    bus1.s_addr = 32'h0;
    bus1.s_data = 64'h0;
    envmem[32'h2000] = 64'h0123_4567_DEAD_BEEF;
    refmem[32'h2000] = 64'h0123_4567_DEAD_BEEF;

    step(1'b0, 1'b1);
    mon_en = 1'b1;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    run(2);

    // single fetch of a preloaded word
    want_req(0, 32'h2000, 64'h0);
    run(5);

    // all three requesters in the same cycle
    want_req(2, 32'h100, 64'h1122_3344_5566_7788);
    want_req(1, 32'h108, 64'h0);
    want_req(0, 32'h110, 64'h0);
    run(8);

    // store followed by a load of the same address
    want_req(2, 32'h200, 64'h0000_0000_0000_A5A5);
    step(1'b0, 1'b0);
    want_req(1, 32'h200, 64'h0);
    run(4);

    // continuous fetch and load
    for (int k = 0; k < 12; k++) begin
      want_req(0, 32'h300, 64'h0);
      want_req(1, 32'h308, 64'h0);
      step(1'b0, 1'b0);
    end
    run(4);

    // reset one cycle after a load grant
    want_req(1, 32'h208, 64'h0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    run(5);

    // randomized traffic with occasional resets
    for (int k = 0; k < 3000; k++) step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) req[i] = 1'b0;
    step(1'b0, 1'b0);
    run(5);

    // RD_LAT=1 instance: back-to-back fetches
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0);
      bus1.f_req  = 1'b1;
      bus1.f_addr = 32'h3000 + 32'(8 * k);
      gq1.push_back('{cyc, 0, bus1.f_addr, 64'h0});
      rq1.push_back('{cyc + 1, 0, bus1.f_addr, dflt(32'h3000 + 32'(8 * k))});
    end
    step(1'b0, 1'b0);
    bus1.f_req = 1'b0;
    run(4);

    chk("grant_queue_drained", 64'(gq.size()), 64'd0);
    chk("rvalid_queue_drained", 64'(rq.size()), 64'd0);
    chk("lat1_queues_drained", 64'(gq1.size() + rq1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
